// File: rtl/bus_slave_pkg.sv
// Shared types for the bus slave: FSM state encoding and burst counter width.
// Imported by bus_sram_slave and its RAM.
package bus_slave_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      READ_END,
      WRITE,
      ERROR
   } state_e;

   // Holds burstSizeIn + 1, so one bit wider than the burst field.
   localparam int BURST_W = 9;

endpackage

// File: rtl/bus_sram_slave_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables.
// Read data appears one cycle after the address is presented.
module bus_sram_slave_ram #(
   parameter int AW = 10
) (
   input  logic          clk_i,
   input  logic [AW-1:0] addr_i,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [2**AW];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_sram_slave.sv
// Burst bus slave fronting a word SRAM window at BASE_ADDR.
// Define BUS_SRAM_SLAVE_BOUNDS_CHECK_EN to reject bursts running off the window.
module bus_sram_slave
   import bus_slave_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
   parameter int          ADDR_WIDTH = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        beginTransactionIn,
   input  logic [31:0] addressDataIn,
   input  logic [7:0]  burstSizeIn,
   input  logic        readNotWriteIn,
   input  logic [3:0]  byteEnablesIn,
   input  logic        dataValidIn,
   input  logic        endTransactionIn,
   output logic [31:0] addressDataOut,
   output logic        dataValidOut,
   output logic        endTransactionOut,
   output logic        busErrorOut
);

   state_e                 state_q;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [BURST_W-1:0]     cnt_q;
   logic                   valid_q;
   logic                   end_q;
   logic                   err_q;

   logic                   sel;
   logic [ADDR_WIDTH-1:0]  word;
   logic                   oob;
   logic                   we;
   logic [31:0]            rdata;

   assign sel  = addressDataIn[31:ADDR_WIDTH+2]
              == BASE_ADDR[31:ADDR_WIDTH+2];
   assign word = addressDataIn[ADDR_WIDTH+1:2];

`ifdef BUS_SRAM_SLAVE_BOUNDS_CHECK_EN
   logic [31:0] last_word;
   assign last_word = 32'(word) + 32'(burstSizeIn);
   assign oob       = last_word > 32'((1 << ADDR_WIDTH) - 1);
`else
   assign oob = 1'b0;
`endif

   // Words past the burst length are dropped; reset blocks the write.
   assign we = (state_q == WRITE) && dataValidIn
            && (cnt_q != '0) && reset;

   bus_sram_slave_ram #(
      .AW (ADDR_WIDTH)
   ) u_ram (
      .clk_i   (clock),
      .addr_i  (addr_q),
      .we_i    (we),
      .be_i    (byteEnablesIn),
      .wdata_i (addressDataIn),
      .rdata_o (rdata)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (beginTransactionIn && sel) begin
                  addr_q <= word;
                  cnt_q  <= BURST_W'(burstSizeIn)
                          + BURST_W'(1);
                  if (oob) begin
                     err_q   <= 1'b1;
                     state_q <= ERROR;
                  end else if (readNotWriteIn) begin
                     state_q <= READ;
                  end else begin
                     state_q <= WRITE;
                  end
               end
            end
            READ: begin
               if (endTransactionIn) begin
                  state_q <= IDLE;
               end else begin
                  valid_q <= 1'b1;
                  addr_q  <= addr_q + 1'b1;
                  cnt_q   <= cnt_q - 1'b1;
                  if (cnt_q == BURST_W'(1)) begin
                     state_q <= READ_END;
                  end
               end
            end
            READ_END: begin
               state_q <= IDLE;
               end_q   <= !endTransactionIn;
            end
            WRITE: begin
               if (we) begin
                  addr_q <= addr_q + 1'b1;
                  cnt_q  <= cnt_q - 1'b1;
               end
               if (endTransactionIn) begin
                  state_q <= IDLE;
               end
            end
            ERROR: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign addressDataOut    = valid_q ? rdata : '0;
   assign dataValidOut      = valid_q;
   assign endTransactionOut = end_q;
   assign busErrorOut       = err_q;

endmodule
